// File: rtl/hydra_pkg.sv
// Shared definitions for the write-side SRAM bind arbiter and its round-robin pickers.
// Holds the port and SRAM counts, the time-stamp width, the index types and the
// match-mode encoding. There is no logic here.
package hydra_pkg;

  localparam int PORT_NUM = 16;
  localparam int SRAM_NUM = 32;
  localparam int TS_W     = 5;
  localparam int PIDX_W   = 4;

  typedef logic [PIDX_W-1:0] port_idx_t;
  typedef logic [TS_W-1:0]   sram_idx_t;

  // Encoding 2'd3 is accepted by the hardware and treated as MODE_FULL.
  typedef enum logic [1:0] {
    MODE_PAIR = 2'd0,
    MODE_HALF = 2'd1,
    MODE_FULL = 2'd2
  } match_mode_e;

endpackage

// File: rtl/rr_pick16.sv
// Combinational 16-way round-robin picker.
// Ports: req_i (request vector), ptr_i (highest-priority index), vld_o (any request),
//        idx_o (first requesting index at or after ptr_i, circular).
module rr_pick16
  import hydra_pkg::*;
(
  input  logic [15:0] req_i,
  input  port_idx_t   ptr_i,
  output logic        vld_o,
  output port_idx_t   idx_o
);

  port_idx_t cand;

  always_comb begin
    vld_o = 1'b0;
    idx_o = ptr_i;
    cand  = ptr_i;
    for (int i = 0; i < 16; i++) begin
      // The 4-bit add wraps 15->0, which gives the circular scan order.
      cand = ptr_i + port_idx_t'(i);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/wr_sram_bind_arbiter.sv
// Shared controller for the 16 per-port write-side SRAM matchers.
// It keeps the global time stamp and each port's rotating candidate SRAM. It gives
// each SRAM to at most one port at a time, using a round-robin pointer per SRAM.
// Ports: clk_i/rst_i (sync, active-high); match_mode_i; time_stamp_o; matching_sram_o
//        (port p at [p*5+:5]); bind_req_i/bind_sram_i/bind_grant_o (request/grant);
//        release_i; port_bound_o/port_sram_o/sram_busy_o (ownership); bind_err_o (sticky).
module wr_sram_bind_arbiter
  import hydra_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               match_mode_i,
  output logic [TS_W-1:0]          time_stamp_o,
  output logic [PORT_NUM*TS_W-1:0] matching_sram_o,
  input  logic [PORT_NUM-1:0]      bind_req_i,
  input  logic [PORT_NUM*TS_W-1:0] bind_sram_i,
  output logic [PORT_NUM-1:0]      bind_grant_o,
  input  logic [PORT_NUM-1:0]      release_i,
  output logic [PORT_NUM-1:0]      port_bound_o,
  output logic [PORT_NUM*TS_W-1:0] port_sram_o,
  output logic [SRAM_NUM-1:0]      sram_busy_o,
  output logic                     bind_err_o
);

  // State
  sram_idx_t                          ts_q, ts_d;
  logic [PORT_NUM-1:0][TS_W-1:0]      matching_q, matching_d;
  logic [PORT_NUM-1:0]                grant_q, grant_d;
  logic [PORT_NUM-1:0]                bound_q, bound_d;
  logic [PORT_NUM-1:0][TS_W-1:0]      psram_q, psram_d;
  logic [SRAM_NUM-1:0]                busy_q, busy_d;
  port_idx_t                          rr_q [SRAM_NUM];
  port_idx_t                          rr_d [SRAM_NUM];
  logic                               err_q, err_d;

  // Combinational
  logic [PORT_NUM-1:0][TS_W-1:0]      bind_sram_w;
  logic [PORT_NUM-1:0]                rel_ok;
  logic [PORT_NUM-1:0]                req_ok;
  logic [SRAM_NUM-1:0]                freeing;
  logic [PORT_NUM-1:0]                req_mat [SRAM_NUM];
  logic [SRAM_NUM-1:0]                pick_vld;
  port_idx_t                          pick_idx [SRAM_NUM];
  sram_idx_t                          base;

  assign bind_sram_w = bind_sram_i;

  // Time stamp and per-port candidate index. The candidate registers sample the
  // current stamp, so they lag time_stamp_o by one cycle.
  always_comb begin
    ts_d       = ts_q + sram_idx_t'(1);
    matching_d = '0;
    base       = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      base = {port_idx_t'(p), 1'b0};
      case (match_mode_i)
        MODE_PAIR: matching_d[p] = {port_idx_t'(p), ts_q[0]};
        MODE_HALF: matching_d[p] = ts_q[0] ? sram_idx_t'(ts_q + base) : base;
        default:   matching_d[p] = ts_q + base;
      endcase
    end
  end

  // A release on a port also suppresses that port's request in the same cycle. The
  // port has to request again once port_bound drops.
  always_comb begin
    rel_ok  = release_i & bound_q;
    req_ok  = bind_req_i & ~bound_q & ~release_i;
    freeing = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (rel_ok[p]) freeing[psram_q[p]] = 1'b1;
    end
  end

  // Each port names one SRAM, so a port appears in at most one row.
  // The port therefore wins at most one SRAM per cycle.
  always_comb begin
    for (int s = 0; s < SRAM_NUM; s++) begin
      req_mat[s] = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
        req_mat[s][p] = req_ok[p] && (bind_sram_w[p] == sram_idx_t'(s)) &&
                        !busy_q[s] && !freeing[s];
      end
    end
  end

  for (genvar s = 0; s < SRAM_NUM; s++) begin : g_pick
    rr_pick16 u_pick (
      .req_i (req_mat[s]),
      .ptr_i (rr_q[s]),
      .vld_o (pick_vld[s]),
      .idx_o (pick_idx[s])
    );
  end

  // Ownership update. A released SRAM is cleared first. Grants can only go to SRAMs
  // that were idle, so the two updates never touch the same SRAM.
  always_comb begin
    bound_d = bound_q;
    psram_d = psram_q;
    busy_d  = busy_q;
    grant_d = '0;
    for (int s = 0; s < SRAM_NUM; s++) rr_d[s] = rr_q[s];

    for (int p = 0; p < PORT_NUM; p++) begin
      if (rel_ok[p]) begin
        bound_d[p]          = 1'b0;
        psram_d[p]          = '0;
        busy_d[psram_q[p]]  = 1'b0;
      end
    end

    for (int s = 0; s < SRAM_NUM; s++) begin
      if (pick_vld[s]) begin
        busy_d[s]            = 1'b1;
        bound_d[pick_idx[s]] = 1'b1;
        psram_d[pick_idx[s]] = sram_idx_t'(s);
        grant_d[pick_idx[s]] = 1'b1;
        rr_d[s]              = pick_idx[s] + port_idx_t'(1);
      end
    end
  end

  // A bound port may still drive its request during its own grant cycle. That is
  // the request being acknowledged, so it does not count as an error.
  always_comb begin
    err_d = err_q
          | (|(release_i & ~bound_q))
          | (|(bind_req_i & bound_q & ~release_i & ~grant_q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q       <= '0;
      matching_q <= '0;
      grant_q    <= '0;
      bound_q    <= '0;
      psram_q    <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
      for (int s = 0; s < SRAM_NUM; s++) rr_q[s] <= '0;
    end else begin
      ts_q       <= ts_d;
      matching_q <= matching_d;
      grant_q    <= grant_d;
      bound_q    <= bound_d;
      psram_q    <= psram_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      for (int s = 0; s < SRAM_NUM; s++) rr_q[s] <= rr_d[s];
    end
  end

  assign time_stamp_o    = ts_q;
  assign matching_sram_o = matching_q;
  assign bind_grant_o    = grant_q;
  assign port_bound_o    = bound_q;
  assign port_sram_o     = psram_q;
  assign sram_busy_o     = busy_q;
  assign bind_err_o      = err_q;

endmodule

// File: doc/wr_sram_bind_arbiter.md
Name: wr_sram_bind_arbiter

Overview:
- Shared controller for the 16 per-port write-side SRAM matchers.
- Owns the global time stamp and generates each port's rotating candidate SRAM index according to the match mode.
- Arbitrates bind requests so each of the 32 SRAMs has at most one writing port, and tracks ownership until the port releases it.
- Exports an SRAM busy mask so matchers skip SRAMs that are already owned.

Parameters:
- PORT_NUM, 16, number of ingress ports/requesters.
- SRAM_NUM, 32, number of SRAM banks.
- TS_W, 5, time-stamp width (log2 SRAM_NUM).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- match_mode  input  2  0: 2-SRAM private pair; 1: 1 private + shared half scan; 2/3: full 32-SRAM scan.
- time_stamp  output  TS_W  free-running cycle counter.
- matching_sram  output  PORT_NUM*TS_W  per-port candidate SRAM index, port p at bits [p*5+:5].
- bind_req  input  PORT_NUM  port p requests ownership of bind_sram[p]; level, held until bind_grant or withdrawn.
- bind_sram  input  PORT_NUM*TS_W  requested SRAM per port.
- bind_grant  output  PORT_NUM  one-cycle grant pulse.
- release  input  PORT_NUM  one-cycle pulse: port p frees its owned SRAM.
- port_bound  output  PORT_NUM  port p currently owns an SRAM.
- port_sram  output  PORT_NUM*TS_W  SRAM owned by port p; 0 when unbound.
- sram_busy  output  SRAM_NUM  ownership mask.
- bind_err  output  1  sticky; set by an illegal request or release.

Behaviour:
- Reset: time_stamp=0, matching_sram=0, bind_grant=0, port_bound=0, port_sram=0, sram_busy=0, bind_err=0, all round-robin pointers=0.
- Reset asserted mid-operation drops all ownership and pending grants on the next edge.
- time_stamp increments by 1 every cycle and wraps 31->0.
- matching_sram[p] is registered, 1-cycle latency from time_stamp (ts), modulo 32:
  - mode 0: {p[3:0], ts[0]}
  - mode 1: ts[0] ? ts + {p[3:0],0} : {p[3:0],0}
  - mode 2/3: ts + {p[3:0],0}
- A match_mode change takes effect on the next edge; no flush.
- Arbitration is evaluated every cycle. A request from port p for SRAM s is eligible when:
  - bind_req[p]=1,
  - port_bound[p]=0,
  - sram_busy[s]=0, and
  - release is not asserted for any port this cycle that frees s.
- Per SRAM, among eligible requesters the winner is the first port index at or after rr_ptr[s], circular 0..15.
- On a win, at the next edge:
  - bind_grant[winner]=1 for exactly one cycle;
  - sram_busy[s]=1, port_bound=1, port_sram=s;
  - rr_ptr[s] = winner+1, wrapping 15->0.
- Different SRAMs are granted in the same cycle independently; up to 16 grants per cycle.
- Losers keep requesting; there is no grant and no error.
- A request from an already-bound port is ignored, sets bind_err, and is never granted.
- release[p] with port_bound[p]=1: next edge clears sram_busy[port_sram[p]], port_bound[p] and port_sram[p].
  - The freed SRAM becomes grantable one cycle after the release edge, never in the same cycle.
- release[p] with port_bound[p]=0: ignored and sets bind_err.
- Same-cycle bind_req and release on port p: the release is processed and the request is ignored that cycle with no error. The port must re-request after port_bound falls.
- bind_sram is sampled every cycle; changing it while waiting is legal.
- bind_err clears only on reset.

Decomposition:
- Shared package hydra_pkg: PORT_NUM, SRAM_NUM, TS_W, port/SRAM index typedefs, and the match_mode enum (MODE_PAIR=0, MODE_HALF=1, MODE_FULL=2).
- One natural sub-module, rr_pick16: combinational 16-request round-robin picker with a 4-bit pointer input, returning valid + winner index. It is instantiated SRAM_NUM times.
- The candidate-index generator stays inline.

Test Plan:
- Reset release, mode 2: ts increments 0,1,2…; port 8 matching_sram = ts_prev+16 mod 32, e.g. 16,17,…,31,0; port 0 mode 0 alternates 0,1; port 3 mode 1 alternates 6, ts+6.
- Single request: port 3 requests SRAM 7 at cycle N -> bind_grant[3] at N+1, sram_busy[7]=1, port_sram[3]=7; release at N+5 -> busy[7]=0 at N+6.
- Contention: ports 2, 5, 9 request SRAM 12 together with rr_ptr[12]=0 -> grant 2 (rr_ptr=3); port 2 releases -> next grant 5, then 9; 5 and 9 never grant while 12 is busy.
- Same-cycle release/request: port 4 owns SRAM 20 and releases while port 6 requests 20 -> no grant that cycle; grant[6] one cycle after busy[20] falls.
- Errors: bound port 1 requests SRAM 2 -> no grant, bind_err=1; unbound port 10 pulses release -> bind_err stays 1, no busy change.
- Reset mid-run: 16 ports bound to SRAMs 0..15, rst pulsed -> all outputs zero next cycle; ts restarts at 0.
